irq_controller: RTL and testbench

Interrupt controller that latches edge-triggered requests from peripherals (timers, RTC, keypad, sound), holds them in bus-visible flag registers, selects the highest-priority pending, enabled source and presents it to the CPU with a vector, then clears it on CPU acknowledge. It sits on the same 24-bit I/O bus as the timer block, at 0x2020–0x2027, between peripheral `irqs` outputs and the CPU interrupt input.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_controller_if.sv | 17 +
 rtl/irq_priority_encoder.sv | 34 +++
 rtl/irq_controller.sv | 144 ++++++++++++++
 tb/tb_irq_controller.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, source count, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

  localparam int NUM_IRQ = 16;

  // I/O register map (24-bit bus)
  localparam logic [23:0] ADDR_PRI0    = 24'h002020;  // priorities, sources 3:0
  localparam logic [23:0] ADDR_PRI1    = 24'h002021;  // priorities, sources 7:4
  localparam logic [23:0] ADDR_PRI2    = 24'h002022;  // priorities, sources 11:8
  localparam logic [23:0] ADDR_PRI3    = 24'h002023;  // priorities, sources 15:12
  localparam logic [23:0] ADDR_EN_LO   = 24'h002024;  // enables 7:0
  localparam logic [23:0] ADDR_EN_HI   = 24'h002025;  // enables 15:8
  localparam logic [23:0] ADDR_FLAG_LO = 24'h002026;  // pending 7:0, write 1 to clear
  localparam logic [23:0] ADDR_FLAG_HI = 24'h002027;  // pending 15:8, write 1 to clear

  typedef logic [1:0] irq_pri_t;

  typedef enum logic [1:0] {IDLE, ASSERT, CLEAR} irq_state_t;

  // A source may interrupt only if pending, enabled, and strictly above the CPU level.
  function automatic logic irq_eligible(input logic flag, input logic en,
                                        input irq_pri_t pri, input logic [1:0] mask);
    return flag && en && (pri != 2'd0) && (pri > mask);
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// I/O bus bundle shared between the CPU-side bus master and the interrupt controller.
// Latency: reads combinational; writes land on the strobe's posedge.
// Backpressure: none; every strobe completes in one cycle.
// Signals: bus_write, bus_read, bus_address_in[23:0], bus_data_in[7:0] (master -> slave),
//          bus_data_out[7:0] (slave -> master).
interface irq_controller_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (output bus_write, bus_read, bus_address_in, bus_data_in,
                  input  bus_data_out);
  modport slave  (input  bus_write, bus_read, bus_address_in, bus_data_in,
                  output bus_data_out);
endinterface

// File: rtl/irq_priority_encoder.sv
// Picks the highest-priority eligible source; ties go to the lowest index.
// Latency: combinational.
// Backpressure: none.
// Ports: flags/enables[15:0], priorities[31:0] (2 bits per source), mask[1:0] in;
//        valid, index[3:0] out.
module irq_priority_encoder
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0]   flags,
  input  logic [NUM_IRQ-1:0]   enables,
  input  logic [2*NUM_IRQ-1:0] priorities,
  input  logic [1:0]           mask,
  output logic                 valid,
  output logic [3:0]           index
);

  irq_pri_t best_pri;

  // Ascending scan with strict '>' keeps the lowest index among equal priorities.
  always_comb begin
    valid    = 1'b0;
    index    = '0;
    best_pri = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_eligible(flags[i], enables[i], priorities[2*i +: 2], mask) &&
          (!valid || (priorities[2*i +: 2] > best_pri))) begin
        valid    = 1'b1;
        index    = i[3:0];
        best_pri = priorities[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Latches peripheral request edges into flags and presents the best eligible source to the CPU.
// Latency: irq_src edge to cpu_irq 2 cycles (4 with IRQ_SYNC_EN defined); ack to flag clear 2 cycles.
// Backpressure: none; cpu_irq holds until ack or until the latched source loses eligibility.
// Ports: clk, reset (sync, active-high); bus (irq_controller_if.slave, regs 0x2020-0x2027);
//        irq_src[15:0], cpu_mask[1:0], cpu_irq_ack in; cpu_irq, cpu_vector[5:0] out.
// Build option: IRQ_SYNC_EN adds a two-flop synchronizer on every irq_src line.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [5:0] VECTOR_BASE = 6'h03
) (
  input  logic                clk,
  input  logic                reset,
  irq_controller_if.slave     bus,
  input  logic [NUM_IRQ-1:0]  irq_src,
  input  logic [1:0]          cpu_mask,
  output logic                cpu_irq,
  output logic [5:0]          cpu_vector,
  input  logic                cpu_irq_ack
);

  logic [2*NUM_IRQ-1:0] pri_q;
  logic [NUM_IRQ-1:0]   en_q, flag_q, flag_d, edge_q, src_s, rise, w1c, done_clr;
  irq_state_t           state_q;
  logic [3:0]           lat_idx_q, win_idx;
  logic                 win_vld, lat_elig, wr_pri;

  // Reads have no side effects, so the read strobe carries no information here.
  logic unused_read;
  assign unused_read = bus.bus_read;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end
  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  assign rise = src_s & ~edge_q;

  // A new edge always wins over a bus clear or the post-ack retire of the same flag.
  always_comb begin
    w1c = '0;
    if (bus.bus_write && (bus.bus_address_in == ADDR_FLAG_LO)) w1c[7:0]  = bus.bus_data_in;
    if (bus.bus_write && (bus.bus_address_in == ADDR_FLAG_HI)) w1c[15:8] = bus.bus_data_in;
    done_clr = '0;
    if (state_q == CLEAR) done_clr[lat_idx_q] = 1'b1;
    flag_d = (flag_q & ~w1c & ~done_clr) | rise;
  end

  assign wr_pri = bus.bus_write && (bus.bus_address_in >= ADDR_PRI0) &&
                  (bus.bus_address_in <= ADDR_PRI3);

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q  <= '0;
      en_q   <= '0;
      flag_q <= '0;
      edge_q <= '0;
    end else begin
      if (wr_pri) pri_q[{bus.bus_address_in[1:0], 3'b000} +: 8] <= bus.bus_data_in;
      if (bus.bus_write && (bus.bus_address_in == ADDR_EN_LO)) en_q[7:0]  <= bus.bus_data_in;
      if (bus.bus_write && (bus.bus_address_in == ADDR_EN_HI)) en_q[15:8] <= bus.bus_data_in;
      flag_q <= flag_d;
      edge_q <= src_s;
    end
  end

  always_comb begin
    bus.bus_data_out = '0;
    case (bus.bus_address_in)
      ADDR_PRI0:    bus.bus_data_out = pri_q[7:0];
      ADDR_PRI1:    bus.bus_data_out = pri_q[15:8];
      ADDR_PRI2:    bus.bus_data_out = pri_q[23:16];
      ADDR_PRI3:    bus.bus_data_out = pri_q[31:24];
      ADDR_EN_LO:   bus.bus_data_out = en_q[7:0];
      ADDR_EN_HI:   bus.bus_data_out = en_q[15:8];
      ADDR_FLAG_LO: bus.bus_data_out = flag_q[7:0];
      ADDR_FLAG_HI: bus.bus_data_out = flag_q[15:8];
      default:      bus.bus_data_out = '0;
    endcase
  end

  irq_priority_encoder u_prio (
    .flags      (flag_q),
    .enables    (en_q),
    .priorities (pri_q),
    .mask       (cpu_mask),
    .valid      (win_vld),
    .index      (win_idx)
  );

  // The latched source is re-checked every cycle; a newer, higher source never preempts it.
  assign lat_elig = irq_eligible(flag_q[lat_idx_q], en_q[lat_idx_q],
                                 pri_q[{lat_idx_q, 1'b0} +: 2], cpu_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_idx_q  <= '0;
      cpu_irq    <= 1'b0;
      cpu_vector <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q    <= ASSERT;
            lat_idx_q  <= win_idx;
            cpu_vector <= VECTOR_BASE + {2'b00, win_idx};
            cpu_irq    <= 1'b1;
          end
        end
        ASSERT: begin
          // Ack takes precedence over a same-cycle loss of eligibility.
          if (cpu_irq_ack) begin
            state_q <= CLEAR;
            cpu_irq <= 1'b0;
          end else if (!lat_elig) begin
            state_q <= IDLE;
            cpu_irq <= 1'b0;
          end
        end
        CLEAR: begin
          state_q <= IDLE;
          cpu_irq <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cpu_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed corner sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_irq_controller;

  localparam logic [5:0] VB = 6'h03;
`ifdef IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = SYNC + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irq_src = '0;
  logic [1:0]  cpu_mask = '0;
  logic        cpu_irq_ack = 1'b0;
  logic        cpu_irq;
  logic [5:0]  cpu_vector;

  irq_controller_if bus ();

  irq_controller #(.VECTOR_BASE(6'h03)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .irq_src     (irq_src),
    .cpu_mask    (cpu_mask),
    .cpu_irq     (cpu_irq),
    .cpu_vector  (cpu_vector),
    .cpu_irq_ack (cpu_irq_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_pri [16];
  bit          m_en  [16];
  bit          m_flag[16];
  logic [15:0] m_prev, m_s1, m_s2;
  int          m_mode;      // 0 nothing presented, 1 presenting m_lat, 2 retiring m_lat
  int          m_lat;
  logic [5:0]  m_vec;

  function automatic logic [7:0] m_read(input logic [23:0] a);
    logic [7:0] r;
    int base;
    r = '0;
    if (a >= 24'h002020 && a <= 24'h002023) begin
      base = 4 * int'(a - 24'h002020);
      for (int j = 0; j < 4; j++) r = r | (8'(m_pri[base+j]) << (2*j));
    end else if (a == 24'h002024) begin
      for (int j = 0; j < 8; j++) r[j] = m_en[j];
    end else if (a == 24'h002025) begin
      for (int j = 0; j < 8; j++) r[j] = m_en[8+j];
    end else if (a == 24'h002026) begin
      for (int j = 0; j < 8; j++) r[j] = m_flag[j];
    end else if (a == 24'h002027) begin
      for (int j = 0; j < 8; j++) r[j] = m_flag[8+j];
    end
    return r;
  endfunction

  function automatic bit m_elig(input int i);
    return m_flag[i] && m_en[i] && (m_pri[i] != 0) && (m_pri[i] > int'(cpu_mask));
  endfunction

  // Highest priority level first, lowest index within a level.
  function automatic int m_winner();
    int w;
    w = -1;
    for (int p = 3; p >= 1; p--)
      for (int i = 0; i < 16; i++)
        if (w < 0 && m_elig(i) && m_pri[i] == p) w = i;
    return w;
  endfunction

  task automatic step();
    logic [15:0] eff, rise, w1c;
    logic [23:0] a;
    logic [7:0]  d;
    int          w;
    bit          lat_ok;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_pri[i] = 0; m_en[i] = 0; m_flag[i] = 0;
      end
      m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_mode = 0; m_lat = 0; m_vec = '0;
    end else begin
      eff    = (SYNC == 0) ? irq_src : m_s2;
      rise   = eff & ~m_prev;
      w      = m_winner();
      lat_ok = m_elig(m_lat);
      w1c    = '0;
      a      = bus.bus_address_in;
      d      = bus.bus_data_in;
      if (bus.bus_write) begin
        if (a >= 24'h002020 && a <= 24'h002023)
          for (int j = 0; j < 4; j++) m_pri[4*int'(a - 24'h002020) + j] = int'(d[2*j +: 2]);
        if (a == 24'h002024) for (int j = 0; j < 8; j++) m_en[j]   = d[j];
        if (a == 24'h002025) for (int j = 0; j < 8; j++) m_en[8+j] = d[j];
        if (a == 24'h002026) w1c[7:0]  = d;
        if (a == 24'h002027) w1c[15:8] = d;
      end
      for (int i = 0; i < 16; i++)
        m_flag[i] = rise[i] || (m_flag[i] && !w1c[i] && !(m_mode == 2 && m_lat == i));
      case (m_mode)
        0: if (w >= 0) begin m_mode = 1; m_lat = w; m_vec = VB + 6'(w); end
        1: if (cpu_irq_ack) m_mode = 2; else if (!lat_ok) m_mode = 0;
        default: m_mode = 0;
      endcase
      m_s2 = m_s1; m_s1 = irq_src; m_prev = eff;
    end
    @(negedge clk);
    check("cpu_irq", cpu_irq, m_mode == 1);
    check("cpu_vector", cpu_vector, m_vec);
    check("bus_data_out", bus.bus_data_out, m_read(bus.bus_address_in));
  endtask

  // ---------------- helpers ----------------
  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus.bus_write = 1'b1; bus.bus_address_in = a; bus.bus_data_in = d;
    step();
    bus.bus_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [23:0] a, input logic [7:0] exp);
    bus.bus_address_in = a; bus.bus_read = 1'b1;
    #1;
    check(name, bus.bus_data_out, exp);
    bus.bus_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = '0; cpu_irq_ack = 1'b0; cpu_mask = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_irq(input string name, input logic [5:0] vec);
    int n;
    n = 0;
    while (!cpu_irq && n < 20) begin step(); n++; end
    check({name, "_irq"}, cpu_irq, 1);
    check({name, "_vec"}, cpu_vector, vec);
  endtask

  task automatic do_ack();
    cpu_irq_ack = 1'b1; step(); cpu_irq_ack = 1'b0;
  endtask

  typedef struct {
    logic [23:0] waddr;
    logic [7:0]  wdata;
    logic [23:0] raddr;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{24'h002020, 8'hA5, 24'h002020, 8'hA5};
    tbl[1]  = '{24'h002021, 8'h3C, 24'h002021, 8'h3C};
    tbl[2]  = '{24'h002022, 8'hFF, 24'h002022, 8'hFF};
    tbl[3]  = '{24'h002023, 8'h01, 24'h002023, 8'h01};
    tbl[4]  = '{24'h002024, 8'h5A, 24'h002024, 8'h5A};
    tbl[5]  = '{24'h002025, 8'hC3, 24'h002025, 8'hC3};
    tbl[6]  = '{24'h002026, 8'hFF, 24'h002026, 8'h00};
    tbl[7]  = '{24'h002027, 8'hFF, 24'h002027, 8'h00};
    tbl[8]  = '{24'h002028, 8'h77, 24'h002028, 8'h00};
    tbl[9]  = '{24'h00201F, 8'h77, 24'h002020, 8'hA5};
    tbl[10] = '{24'h012020, 8'h77, 24'h002020, 8'hA5};
    tbl[11] = '{24'h012020, 8'h77, 24'h012020, 8'h00};

    bus.bus_write = 1'b0; bus.bus_read = 1'b0;
    bus.bus_address_in = 24'h002020; bus.bus_data_in = '0;

    do_reset();
    for (int a = 0; a < 8; a++) rd($sformatf("reset_rd%0d", a), 24'h002020 + 24'(a), 8'h00);
    check("reset_irq", cpu_irq, 0);
    check("reset_vec", cpu_vector, 0);

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
    end

    // Single source: exact latency, vector, ack retire timing.
    do_reset();
    wr(24'h002020, 8'h80);
    wr(24'h002024, 8'h08);
    irq_src[3] = 1'b1; step(); irq_src[3] = 1'b0;
    check("t1_early", cpu_irq, 0);
    repeat (LAT - 2) step();
    step();
    check("t1_irq", cpu_irq, 1);
    check("t1_vec", cpu_vector, 6'h06);
    rd("t1_flag_set", 24'h002026, 8'h08);
    do_ack();
    check("t1_clear_irq", cpu_irq, 0);
    step();
    rd("t1_flag_clr", 24'h002026, 8'h00);

    // Priority order across sources 1 (pri 1) and 9 (pri 3).
    do_reset();
    wr(24'h002020, 8'h04); wr(24'h002022, 8'h0C);
    wr(24'h002024, 8'h02); wr(24'h002025, 8'h02);
    irq_src = 16'h0202; step(); irq_src = '0;
    wait_irq("t2_first", 6'h0C);
    do_ack();
    wait_irq("t2_second", 6'h04);
    do_ack(); step(); step();
    check("t2_done", cpu_irq, 0);

    // Equal priority: lowest index first.
    do_reset();
    wr(24'h002020, 8'h20); wr(24'h002021, 8'h08); wr(24'h002024, 8'h24);
    irq_src = 16'h0024; step(); irq_src = '0;
    wait_irq("t3_first", 6'h05);
    do_ack();
    wait_irq("t3_second", 6'h08);
    do_ack(); step();

    // CPU mask blocks, then W1C withdraws the request without ack.
    do_reset();
    wr(24'h002021, 8'h01); wr(24'h002024, 8'h10);
    cpu_mask = 2'd1;
    irq_src = 16'h0010; step(); irq_src = '0;
    repeat (LAT + 4) step();
    check("t4_masked", cpu_irq, 0);
    rd("t4_pending", 24'h002026, 8'h10);
    cpu_mask = 2'd0;
    wait_irq("t4", 6'h07);
    wr(24'h002026, 8'h10);
    check("t4_hold", cpu_irq, 1);
    step();
    check("t4_drop", cpu_irq, 0);
    repeat (3) step();
    check("t4_stay_idle", cpu_irq, 0);
    rd("t4_flag", 24'h002026, 8'h00);

    // Edge and W1C on the same flag in the same cycle: the edge wins.
    do_reset();
    irq_src[0] = 1'b1;
    repeat (SYNC) step();
    wr(24'h002026, 8'h01);
    irq_src[0] = 1'b0;
    rd("t5_flag", 24'h002026, 8'h01);

    // Reset while asserting.
    do_reset();
    wr(24'h002020, 8'h80); wr(24'h002024, 8'h08);
    irq_src = 16'h0008; step(); irq_src = '0;
    wait_irq("t6", 6'h06);
    reset = 1'b1;
    step();
    check("t6_irq", cpu_irq, 0);
    check("t6_vec", cpu_vector, 0);
    for (int a = 0; a < 8; a++) rd($sformatf("t6_rd%0d", a), 24'h002020 + 24'(a), 8'h00);
    reset = 1'b0;
    step();
    check("t6_after", cpu_irq, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      irq_src = irq_src ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) cpu_mask = 2'($urandom);
      cpu_irq_ack = (cpu_irq && $urandom_range(0, 3) == 0) || ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.bus_write      = 1'b1;
        bus.bus_address_in = 24'h002020 + 24'($urandom_range(0, 8));
        bus.bus_data_in    = 8'($urandom);
      end else begin
        bus.bus_write      = 1'b0;
        bus.bus_address_in = 24'h002020 + 24'($urandom_range(0, 7));
      end
      step();
    end
    reset = 1'b0; bus.bus_write = 1'b0; cpu_irq_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
